// File: rtl/multi_alarm_clock_if.sv
// Keypad, button, alarm-control and display signals of multi_alarm_clock.
// The master drives the controls and the slave (the clock) drives the display and alarm status.
interface multi_alarm_clock_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  one_minute;
  logic [3:0]            key;
  logic                  key_valid;
  logic                  time_button;
  logic                  alarm_button;
  logic [SEL_W-1:0]      alarm_sel;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  show_alarm;
  logic                  stop_button;
  logic                  snooze_button;
  logic [7:0]            ms_hour;
  logic [7:0]            ls_hour;
  logic [7:0]            ms_minute;
  logic [7:0]            ls_minute;
  logic                  alarm_sound;
  logic [SEL_W-1:0]      ring_id;
  logic                  load_err;

  modport master (
    output one_minute, key, key_valid, time_button, alarm_button, alarm_sel,
           alarm_en, show_alarm, stop_button, snooze_button,
    input  ms_hour, ls_hour, ms_minute, ls_minute, alarm_sound, ring_id, load_err
  );

  modport slave (
    input  one_minute, key, key_valid, time_button, alarm_button, alarm_sel,
           alarm_en, show_alarm, stop_button, snooze_button,
    output ms_hour, ls_hour, ms_minute, ls_minute, alarm_sound, ring_id, load_err
  );
endinterface

// File: rtl/multi_alarm_clock.sv
// BCD alarm clock with NUM_ALARMS channels, keypad loading and a ring/snooze controller.
// The snooze feature (SNOOZED state, snooze count, minute down-counter) is built only with ALARM_SNOOZE_EN.
module multi_alarm_clock #(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                clock,
  input  logic                reset_delay,
  multi_alarm_clock_if.slave  bus
);
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZED = 2'd2;

  logic [15:0]      key_buf;
  logic [15:0]      cur_time;
  logic [15:0]      next_min;
  logic [15:0]      disp_bcd;
  logic [15:0]      alarm_time [NUM_ALARMS];
  logic [1:0]       state;
  logic [SEL_W-1:0] ring_id_q;
  logic             load_err_q;
  logic             time_upd;
  logic             buf_ok;
  logic             time_load;
  logic             alarm_load;
  logic             tick;
  logic             ring_en;
  logic             match_hit;
  logic [SEL_W-1:0] match_idx;

`ifdef ALARM_SNOOZE_EN
  logic [2:0]       snz_cnt;
  logic [3:0]       snz_left;
`else
  logic             unused_snooze;
  assign unused_snooze = bus.snooze_button ^ (SNOOZE_MIN == 0) ^ (MAX_SNOOZE == 0);
`endif

  // Buffer holds HH:MM as BCD; hours 00..23 and minutes 00..59 are loadable.
  always_comb begin
    buf_ok = (key_buf[15:12] <= 4'd2) && (key_buf[11:8] <= 4'd9) &&
             ((key_buf[15:12] != 4'd2) || (key_buf[11:8] <= 4'd3)) &&
             (key_buf[7:4] <= 4'd5) && (key_buf[3:0] <= 4'd9);
  end

  assign time_load  = bus.time_button && buf_ok;
  assign alarm_load = bus.alarm_button && buf_ok;
  // A time load in the same cycle swallows the minute tick.
  assign tick       = bus.one_minute && !bus.time_button;
  assign ring_en    = bus.alarm_en[ring_id_q];

  always_comb begin
    next_min = cur_time;
    if (cur_time[3:0] != 4'd9) begin
      next_min[3:0] = cur_time[3:0] + 4'd1;
    end else begin
      next_min[3:0] = '0;
      if (cur_time[7:4] != 4'd5) begin
        next_min[7:4] = cur_time[7:4] + 4'd1;
      end else begin
        next_min[7:4] = '0;
        if (cur_time[15:8] == 8'h23) begin
          next_min[15:8] = '0;
        end else if (cur_time[11:8] == 4'd9) begin
          next_min[11:8]  = '0;
          next_min[15:12] = cur_time[15:12] + 4'd1;
        end else begin
          next_min[11:8] = cur_time[11:8] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (!match_hit && bus.alarm_en[i] && (alarm_time[i] == cur_time)) begin
        match_hit = 1'b1;
        match_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset_delay) begin
    if (reset_delay) begin
      key_buf    <= '0;
      cur_time   <= '0;
      disp_bcd   <= '0;
      time_upd   <= 1'b0;
      load_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        alarm_time[i] <= '0;
      end
    end else begin
      load_err_q <= (bus.time_button || bus.alarm_button) && !buf_ok;
      disp_bcd   <= bus.show_alarm ? alarm_time[bus.alarm_sel] : cur_time;
      if (bus.key_valid && (bus.key <= 4'd9)) begin
        key_buf <= {key_buf[11:0], bus.key};
      end
      if (time_load) begin
        cur_time <= key_buf;
      end else if (tick) begin
        cur_time <= next_min;
      end
      // Matching only follows a time change, so a stopped alarm cannot re-ring in its minute.
      time_upd <= time_load || tick;
      if (alarm_load) begin
        alarm_time[bus.alarm_sel] <= key_buf;
      end
    end
  end

  always_ff @(posedge clock or posedge reset_delay) begin
    if (reset_delay) begin
      state     <= IDLE;
      ring_id_q <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt   <= '0;
      snz_left  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!time_load && time_upd && match_hit) begin
            state     <= RINGING;
            ring_id_q <= match_idx;
`ifdef ALARM_SNOOZE_EN
            snz_cnt   <= '0;
`endif
          end
        end
        RINGING: begin
          if (time_load || !ring_en || bus.stop_button) begin
            state <= IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.snooze_button) begin
            if (snz_cnt < 3'(MAX_SNOOZE)) begin
              state    <= SNOOZED;
              snz_left <= 4'(SNOOZE_MIN);
              snz_cnt  <= snz_cnt + 3'd1;
            end else begin
              state <= IDLE;
            end
`endif
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZED: begin
          if (time_load || !ring_en || bus.stop_button) begin
            state <= IDLE;
          end else if (bus.one_minute) begin
            snz_left <= snz_left - 4'd1;
            if (snz_left == 4'd1) begin
              state <= RINGING;
            end
          end
        end
`else
        SNOOZED: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alarm_sound = (state == RINGING);
  assign bus.ring_id     = ring_id_q;
  assign bus.load_err    = load_err_q;
  assign bus.ms_hour     = {4'h3, disp_bcd[15:12]};
  assign bus.ls_hour     = {4'h3, disp_bcd[11:8]};
  assign bus.ms_minute   = {4'h3, disp_bcd[7:4]};
  assign bus.ls_minute   = {4'h3, disp_bcd[3:0]};
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: vector table, directed ring/snooze/reset
// sequences, and randomized traffic against a minutes-of-day reference model.
module tb_multi_alarm_clock;
  localparam int NA         = 4;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;

  logic clock = 1'b0;
  logic reset_delay = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  multi_alarm_clock_if #(.NUM_ALARMS(NA)) ifc ();

  multi_alarm_clock #(
    .NUM_ALARMS(NA),
    .SNOOZE_MIN(SNOOZE_MIN),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clock      (clock),
    .reset_delay(reset_delay),
    .bus        (ifc.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  key;
    logic        kv, tb, ab, tick, show;
    logic [1:0]  sel;
    logic [15:0] exp_disp;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  // reference model state: times as minutes of day, buffer as a 4-digit decimal
  int m_time, m_buf, m_id, m_cnt, m_left, m_disp;
  int m_alarm[NA];
  bit m_ring, m_snz, m_upd, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] disp_act();
    return {ifc.ms_hour, ifc.ls_hour, ifc.ms_minute, ifc.ls_minute};
  endfunction

  function automatic logic [31:0] asc_bcd(input logic [15:0] b);
    return {4'h3, b[15:12], 4'h3, b[11:8], 4'h3, b[7:4], 4'h3, b[3:0]};
  endfunction

  function automatic logic [31:0] asc_min(input int v);
    int h, m;
    h = v / 60;
    m = v % 60;
    return {8'(48 + h / 10), 8'(48 + h % 10), 8'(48 + m / 10), 8'(48 + m % 10)};
  endfunction

  task automatic clear_strobes();
    ifc.key_valid     = 1'b0;
    ifc.time_button   = 1'b0;
    ifc.alarm_button  = 1'b0;
    ifc.one_minute    = 1'b0;
    ifc.stop_button   = 1'b0;
    ifc.snooze_button = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    clear_strobes();
  endtask

  task automatic do_reset(input bit check_it);
    reset_delay = 1'b1;
    clear_strobes();
    ifc.key = 4'hA;
    ifc.alarm_sel = '0;
    ifc.alarm_en = '0;
    ifc.show_alarm = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    if (check_it) begin
      check("reset_disp", disp_act(), 32'h30303030);
      check("reset_flags", {30'b0, ifc.alarm_sound, ifc.load_err}, 32'h0);
      check("reset_ring_id", {30'b0, ifc.ring_id}, 32'h0);
    end
    reset_delay = 1'b0;
  endtask

  task automatic enter_digits(input int d3, input int d2, input int d1, input int d0);
    int d[4];
    d = '{d3, d2, d1, d0};
    foreach (d[i]) begin
      ifc.key = 4'(d[i]);
      ifc.key_valid = 1'b1;
      cycle();
    end
  endtask

  task automatic add(input int key, input bit kv, input bit tb, input bit ab, input bit tick,
                     input bit show, input int sel, input logic [15:0] disp, input bit err);
    vec_t v;
    v.key = 4'(key); v.kv = kv; v.tb = tb; v.ab = ab; v.tick = tick;
    v.show = show; v.sel = 2'(sel); v.exp_disp = disp; v.exp_err = err;
    vq.push_back(v);
  endtask

  // Ring alarm 0 at 07:30 with alarm 2 also at 07:30 and enabled.
  task automatic setup_ring(input string tag);
    do_reset(1'b0);
    enter_digits(0, 7, 3, 0);
    ifc.alarm_button = 1'b1; ifc.alarm_sel = 2'd0; cycle();
    ifc.alarm_button = 1'b1; ifc.alarm_sel = 2'd2; cycle();
    enter_digits(0, 7, 2, 9);
    ifc.time_button = 1'b1; cycle();
    ifc.alarm_en = 4'b0101;
    ifc.one_minute = 1'b1; cycle();
    check({tag, "_match_latency"}, {31'b0, ifc.alarm_sound}, 32'h0);
    cycle();
    check({tag, "_ringing"}, {31'b0, ifc.alarm_sound}, 32'h1);
    check({tag, "_ring_id"}, {30'b0, ifc.ring_id}, 32'h0);
  endtask

  task automatic model_reset();
    m_time = 0; m_buf = 0; m_id = 0; m_cnt = 0; m_left = 0; m_disp = 0;
    m_ring = 0; m_snz = 0; m_upd = 0; m_err = 0;
    foreach (m_alarm[i]) m_alarm[i] = 0;
  endtask

  task automatic model_step();
    int hh, mm, bval, sel, n_disp, hit;
    bit ok, tb, ab;
    tb = ifc.time_button;
    ab = ifc.alarm_button;
    hh = m_buf / 100;
    mm = m_buf % 100;
    ok = (hh <= 23) && (mm <= 59);
    bval = hh * 60 + mm;
    sel = int'(ifc.alarm_sel);
    n_disp = ifc.show_alarm ? m_alarm[sel] : m_time;
    if (tb && ok) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring || m_snz) begin
      if (!ifc.alarm_en[m_id] || ifc.stop_button) begin
        m_ring = 0; m_snz = 0;
      end
`ifdef ALARM_SNOOZE_EN
      else if (m_ring && ifc.snooze_button) begin
        m_ring = 0;
        if (m_cnt < MAX_SNOOZE) begin
          m_snz = 1; m_left = SNOOZE_MIN; m_cnt++;
        end
      end else if (m_snz && ifc.one_minute) begin
        m_left--;
        if (m_left == 0) begin
          m_snz = 0; m_ring = 1;
        end
      end
`endif
    end else if (m_upd) begin
      hit = -1;
      for (int i = 0; i < NA; i++)
        if (hit < 0 && ifc.alarm_en[i] && m_alarm[i] == m_time) hit = i;
      if (hit >= 0) begin
        m_ring = 1; m_id = hit; m_cnt = 0;
      end
    end
    m_upd = tb ? ok : ifc.one_minute;
    if (tb) begin
      if (ok) m_time = bval;
    end else if (ifc.one_minute) begin
      m_time = (m_time + 1) % 1440;
    end
    if (ab && ok) m_alarm[sel] = bval;
    if (ifc.key_valid && ifc.key <= 9) m_buf = (m_buf % 1000) * 10 + int'(ifc.key);
    m_disp = n_disp;
    m_err = (tb || ab) && !ok;
  endtask

  initial begin
    clear_strobes();
    ifc.key = 4'hA; ifc.alarm_sel = '0; ifc.alarm_en = '0; ifc.show_alarm = 1'b0;

    // key, kv, tb, ab, tick, show, sel, expected display (BCD), expected load_err
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(2, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(5, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000, 1);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(1, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(10, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(2, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 0, 1, 0, 1, 0, 0, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 16'h1200, 0);
    add(0, 0, 0, 0, 1, 0, 0, 16'h1200, 0);
    add(0, 0, 0, 0, 0, 0, 0, 16'h1201, 0);
    add(0, 0, 0, 1, 0, 0, 1, 16'h1201, 0);
    add(0, 0, 0, 0, 0, 1, 1, 16'h1200, 0);
    add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 0);
    add(2, 1, 0, 0, 0, 0, 0, 16'h1201, 0);
    add(3, 1, 0, 0, 0, 0, 0, 16'h1201, 0);
    add(5, 1, 0, 0, 0, 0, 0, 16'h1201, 0);
    add(9, 1, 0, 0, 0, 0, 0, 16'h1201, 0);
    add(0, 0, 1, 0, 0, 0, 0, 16'h1201, 0);
    add(0, 0, 0, 0, 0, 0, 0, 16'h2359, 0);
    add(0, 0, 0, 0, 1, 0, 0, 16'h2359, 0);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(7, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 0, 0, 1, 0, 0, 2, 16'h0000, 1);
    add(0, 0, 0, 0, 0, 1, 1, 16'h1200, 0);
    add(0, 0, 0, 0, 0, 1, 2, 16'h0000, 0);

    do_reset(1'b1);
    foreach (vq[i]) begin
      ifc.key = vq[i].key; ifc.key_valid = vq[i].kv; ifc.time_button = vq[i].tb;
      ifc.alarm_button = vq[i].ab; ifc.one_minute = vq[i].tick;
      ifc.show_alarm = vq[i].show; ifc.alarm_sel = vq[i].sel;
      cycle();
      check($sformatf("vec%0d_disp", i), disp_act(), asc_bcd(vq[i].exp_disp));
      check($sformatf("vec%0d_err_sound", i), {30'b0, ifc.load_err, ifc.alarm_sound},
            {30'b0, vq[i].exp_err, 1'b0});
    end
    ifc.show_alarm = 1'b0;

    // snooze cycle, or snooze ignored when the feature is absent
    setup_ring("snz");
`ifdef ALARM_SNOOZE_EN
    for (int p = 1; p <= 3; p++) begin
      ifc.snooze_button = 1'b1; cycle();
      check($sformatf("snooze%0d_silent", p), {31'b0, ifc.alarm_sound}, 32'h0);
      for (int t = 1; t <= 5; t++) begin
        ifc.one_minute = 1'b1; cycle();
        check($sformatf("snooze%0d_tick%0d", p, t), {31'b0, ifc.alarm_sound}, {31'b0, t == 5});
      end
      cycle();
      check($sformatf("snooze%0d_time", p), disp_act(), asc_min(450 + 5 * p));
    end
    ifc.snooze_button = 1'b1; cycle();
    check("snooze_limit_stop", {31'b0, ifc.alarm_sound}, 32'h0);
    repeat (6) begin ifc.one_minute = 1'b1; cycle(); end
    check("snooze_limit_idle", {31'b0, ifc.alarm_sound}, 32'h0);
`else
    ifc.snooze_button = 1'b1; cycle();
    check("snooze_ignored", {31'b0, ifc.alarm_sound}, 32'h1);
    ifc.stop_button = 1'b1; cycle();
    check("snooze_off_stop", {31'b0, ifc.alarm_sound}, 32'h0);
`endif

    // stop and snooze together: stop wins, no re-ring later in the minute or after
    setup_ring("stop");
    ifc.stop_button = 1'b1; ifc.snooze_button = 1'b1; cycle();
    check("stop_wins", {31'b0, ifc.alarm_sound}, 32'h0);
    repeat (3) cycle();
    check("no_rering_same_min", {31'b0, ifc.alarm_sound}, 32'h0);
    repeat (6) begin ifc.one_minute = 1'b1; cycle(); end
    check("stop_not_snoozed", {31'b0, ifc.alarm_sound}, 32'h0);

    setup_ring("enclr");
    ifc.alarm_en = 4'b0100; cycle();
    check("enable_clear_idle", {31'b0, ifc.alarm_sound}, 32'h0);

    setup_ring("tload");
    ifc.time_button = 1'b1; cycle();
    check("time_load_idle", {31'b0, ifc.alarm_sound}, 32'h0);

    setup_ring("rst");
    #2 reset_delay = 1'b1;
    #1;
    check("async_reset_sound", {31'b0, ifc.alarm_sound}, 32'h0);
    check("async_reset_disp", disp_act(), 32'h30303030);
    @(posedge clock);
    #1 reset_delay = 1'b0;
    repeat (3) cycle();
    check("reset_no_stale_match", {31'b0, ifc.alarm_sound}, 32'h0);

    // randomized traffic against the reference model
    do_reset(1'b0);
    model_reset();
    ifc.alarm_en = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      ifc.key           = 4'($urandom_range(0, 10));
      ifc.key_valid     = ($urandom_range(0, 99) < 35);
      ifc.time_button   = ($urandom_range(0, 99) < 3);
      ifc.alarm_button  = ($urandom_range(0, 99) < 6);
      ifc.one_minute    = ($urandom_range(0, 99) < 40);
      ifc.stop_button   = ($urandom_range(0, 99) < 3);
      ifc.snooze_button = ($urandom_range(0, 99) < 10);
      ifc.show_alarm    = ($urandom_range(0, 99) < 25);
      ifc.alarm_sel     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) ifc.alarm_en = 4'($urandom);
      model_step();
      cycle();
      check($sformatf("rand%0d_disp", n), disp_act(), asc_min(m_disp));
      check($sformatf("rand%0d_sound_err", n), {30'b0, ifc.alarm_sound, ifc.load_err},
            {30'b0, m_ring, m_err});
      check($sformatf("rand%0d_ring_id", n), {30'b0, ifc.ring_id}, 32'(m_id));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
Parameters (name, default, meaning):
REQ-001 NUM_ALARMS, 4, number of independent alarm channels, legal range 1..8.
REQ-002 SNOOZE_MIN, 5, snooze interval in minutes, legal range 1..9.
REQ-003 MAX_SNOOZE, 3, number of snoozes allowed per alarm event, legal range 1..7.
Ports (name, direction, width, meaning):
REQ-004 clock, input, 1, system clock; all state changes on rising edge.
REQ-005 reset_delay, input, 1, reset; asynchronous, active-high.
REQ-006 one_minute, input, 1, single-cycle minute tick from timegen.
REQ-007 key, input, 4, keypad digit; 0-9 valid, 4'hA = no key.
REQ-008 key_valid, input, 1, single-cycle strobe that qualifies key.
REQ-009 time_button, input, 1, single-cycle strobe that loads the key buffer into current time.
REQ-010 alarm_button, input, 1, single-cycle strobe that loads the key buffer into alarm[alarm_sel].
REQ-011 alarm_sel, input, $clog2(NUM_ALARMS) (min 1), target or displayed alarm channel.
REQ-012 alarm_en, input, NUM_ALARMS, per-channel arm mask.
REQ-013 show_alarm, input, 1, display alarm[alarm_sel] instead of current time.
REQ-014 stop_button, input, 1, single-cycle strobe that silences the ringing alarm.
REQ-015 snooze_button, input, 1, single-cycle strobe that snoozes the ringing alarm.
REQ-016 ms_hour/ls_hour/ms_minute/ls_minute, output, 8 each, ASCII digits (8'h30 + BCD).
REQ-017 alarm_sound, output, 1, high while in RINGING.
REQ-018 ring_id, output, $clog2(NUM_ALARMS) (min 1), index of the ringing or snoozed channel.
REQ-019 load_err, output, 1, one-cycle pulse on a rejected load.

Function
REQ-020 Key buffer: four BCD digits; each key_valid with key<=9 shifts left one digit and inserts key at the least significant minute digit; key>9 is ignored.
REQ-021 Load validity: a load is valid only if hours<=23 and minutes<=59; an invalid load leaves all registers unchanged and pulses load_err in the next cycle.
REQ-022 Current time: BCD HH:MM, increments on one_minute; 09->10 digit carry; minute 59->00 carries into the hour; 23:59 wraps to 00:00.
REQ-023 If time_button and one_minute occur in the same cycle, the load wins and the tick is dropped.
REQ-024 If time_button and alarm_button occur in the same cycle, both loads occur from the same buffer.
REQ-025 Display: the outputs are registered with 1-cycle latency from the source register and show alarm[alarm_sel] when show_alarm=1, otherwise current time.
REQ-026 Match: evaluated in the cycle after the current time updates; a channel matches if alarm_en[i]=1 and alarm[i] equals the current time; the lowest matching index wins.
REQ-027 FSM IDLE: on a match, go to RINGING, latch ring_id, clear the snooze count.
REQ-028 FSM RINGING: stop_button returns to IDLE; snooze_button with count<MAX_SNOOZE goes to SNOOZED, loads the minute down-counter with SNOOZE_MIN, and increments the count; snooze_button with count=MAX_SNOOZE behaves as stop.
REQ-029 FSM SNOOZED: each one_minute decrements the down-counter; at zero, go back to RINGING; stop_button returns to IDLE.
REQ-030 If stop_button and snooze_button occur in the same cycle, stop wins.
REQ-031 In RINGING or SNOOZED, new matches are ignored.
REQ-032 If alarm_en[ring_id] is cleared while in RINGING or SNOOZED, the FSM returns to IDLE on the next cycle.
REQ-033 A time load moves RINGING or SNOOZED to IDLE.
REQ-034 A match re-arms only after the time leaves the matching minute, so there is no re-ring after a stop within the same minute.

Reset
REQ-035 reset_delay high asynchronously forces: current time 00:00; all alarms 00:00; key buffer 0000; FSM IDLE; snooze count and down-counter 0.
REQ-036 During reset, all display outputs are 8'h30, alarm_sound=0, ring_id=0, load_err=0.
REQ-037 Reset asserted mid-ring or mid-snooze silences immediately; after release, the first match requires a fresh minute update.

Configuration
REQ-038 Macro ALARM_SNOOZE_EN: when defined, the SNOOZED state, snooze count, and down-counter are present as specified.
REQ-039 When ALARM_SNOOZE_EN is undefined, snooze_button is ignored, SNOOZED is unreachable, and RINGING exits only via stop, enable clear, time load, or reset.

Verification
REQ-040 Rollover: load 23:59, one one_minute -> display "00:00" (all outputs 8'h30), no load_err.
REQ-041 Invalid load: keys 2,5,0,0 then time_button -> load_err pulses one cycle, time unchanged.
REQ-042 Multi-match: alarms 0 and 2 both 07:30 and enabled, time 07:29, tick -> alarm_sound=1, ring_id=0.
REQ-043 Snooze (ALARM_SNOOZE_EN): ring at 07:30, snooze, 5 ticks -> RINGING at 07:35; after a 4th snooze press -> IDLE, alarm_sound=0.
REQ-044 Collision: time_button and one_minute in the same cycle with buffer 12:00 -> time 12:00, not 12:01.
REQ-045 Reset mid-ring: assert reset_delay while alarm_sound=1 -> alarm_sound=0 asynchronously, all displays 8'h30.
